// File: rtl/computer_pkg.sv
// Shared widths and read-return ownership tags for the CPU/memory subsystem.
package computer_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data ports.
// Data has fixed priority; a wait counter lets a starved fetch win one grant.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = computer_pkg::ADDR_W,
    parameter int unsigned DATA_W   = computer_pkg::DATA_W,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);
    import computer_pkg::*;

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic [3:0]        wait_cnt_q, wait_cnt_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              starve;

    always_comb begin
        i_gnt  = 1'b0;
        d_gnt  = 1'b0;
        starve = i_req && (wait_cnt_q >= MaxWait);
        if (!rst) begin
            if (d_req && !starve) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    // Address/wdata hold their last granted values so the RAM pins stay quiet when idle.
    always_comb begin
        m_en    = i_gnt | d_gnt;
        m_we    = d_gnt & d_we;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        if (d_gnt) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (i_gnt) begin
            m_addr = i_addr;
        end
        addr_d  = m_addr;
        wdata_d = m_wdata;
    end

    always_comb begin
        wait_cnt_d = 4'd0;
        if (i_req && !i_gnt) begin
            wait_cnt_d = (wait_cnt_q >= MaxWait) ? MaxWait : wait_cnt_q + 4'd1;
        end
        owner_d = OWN_NONE;
        if (d_gnt && !d_we) begin
            owner_d = OWN_D;
        end else if (i_gnt) begin
            owner_d = OWN_I;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 4'd0;
            owner_q    <= OWN_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign i_rvalid = (owner_q == OWN_I);
    assign d_rvalid = (owner_q == OWN_D);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule
